// File: rtl/htree_tap_phase_cal_if.sv
// Interface between the HTree tap phase calibrator and its controller.
// The master side drives the measurement request and presents the delay-line
// taps; the slave side (the calibrator) returns status and the averaged result.
interface htree_tap_phase_cal_if #(
    parameter int NTAPS = 8
);
    localparam int RW = $clog2(NTAPS + 1);

    logic             start;
    logic [NTAPS-1:0] taps_in;
    logic             busy;
    logic [RW-1:0]    result;
    logic             result_valid;
    logic             bubble_err;

    modport master (
        output start,
        output taps_in,
        input  busy,
        input  result,
        input  result_valid,
        input  bubble_err
    );

    modport slave (
        input  start,
        input  taps_in,
        output busy,
        output result,
        output result_valid,
        output bubble_err
    );
endinterface

// File: rtl/htree_tap_phase_cal.sv
// HTree tap phase calibrator.
// Captures the delay-line taps as a thermometer code for 2^AVG_LOG2 cycles,
// decodes each sample to an edge position, and reports the truncated average.
// Optional build macro: HTREE_CAL_BUBBLE_FIX_EN selects a popcount decode that
// tolerates bubbles and never flags bubble_err. Without it, the decode counts
// leading ones from bit 0 and any 1 above the first 0 flags a bubble.
module htree_tap_phase_cal #(
    parameter int NTAPS    = 8,
    parameter int AVG_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    htree_tap_phase_cal_if.slave cal
);
    localparam int RW = $clog2(NTAPS + 1);
    localparam int AW = RW + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST_CAPTURE = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NTAPS-1:0] cap_q;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    sampleCnt_q, sampleCnt_d;
    logic             runBubble_q, runBubble_d;
    logic [RW-1:0]    result_q;
    logic             resultValid_q;
    logic             bubbleErr_q;
    logic             capEn;
    logic [RW-1:0]    code;
    logic             bubble;
`ifndef HTREE_CAL_BUBBLE_FIX_EN
    logic             seenZero;
`endif

`ifdef HTREE_CAL_BUBBLE_FIX_EN
    // Bubble-tolerant decode: edge position is the number of set taps.
    always_comb begin
        code   = '0;
        bubble = 1'b0;
        for (int k = 0; k < NTAPS; k++) begin
            code = code + RW'(cap_q[k]);
        end
    end
`else
    // Leading-ones decode: count 1s from bit 0 until the first 0; any later 1 is a bubble.
    always_comb begin
        code     = '0;
        bubble   = 1'b0;
        seenZero = 1'b0;
        for (int k = 0; k < NTAPS; k++) begin
            if (seenZero) begin
                if (cap_q[k]) begin
                    bubble = 1'b1;
                end
            end else if (cap_q[k]) begin
                code = code + RW'(1);
            end else begin
                seenZero = 1'b1;
            end
        end
    end
`endif

    // Next-state logic: the capture stage runs one cycle ahead of accumulation, so the
    // first RUN cycle only captures and DRAIN folds in the final captured sample.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sampleCnt_d = sampleCnt_q;
        runBubble_d = runBubble_q;
        capEn       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cal.start) begin
                    state_d     = RUN;
                    acc_d       = '0;
                    sampleCnt_d = '0;
                    runBubble_d = 1'b0;
                end
            end
            RUN: begin
                capEn       = 1'b1;
                sampleCnt_d = sampleCnt_q + CW'(1);
                if (sampleCnt_q != '0) begin
                    acc_d       = acc_q + AW'(code);
                    runBubble_d = runBubble_q | bubble;
                end
                if (sampleCnt_q == LAST_CAPTURE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                acc_d       = acc_q + AW'(code);
                runBubble_d = runBubble_q | bubble;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture and output registers; the result is loaded on the edge leaving DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cap_q         <= '0;
            acc_q         <= '0;
            sampleCnt_q   <= '0;
            runBubble_q   <= 1'b0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            bubbleErr_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            sampleCnt_q   <= sampleCnt_d;
            runBubble_q   <= runBubble_d;
            resultValid_q <= (state_q == DRAIN);
            if (capEn) begin
                cap_q <= cal.taps_in;
            end
            if (state_q == DRAIN) begin
                result_q    <= acc_d[AW-1:AVG_LOG2];
                bubbleErr_q <= runBubble_d;
            end
        end
    end

    assign cal.busy         = (state_q != IDLE);
    assign cal.result       = result_q;
    assign cal.result_valid = resultValid_q;
    assign cal.bubble_err   = bubbleErr_q;
endmodule

// File: tb/tb_htree_tap_phase_cal.sv
// Testbench for htree_tap_phase_cal: directed runs plus randomized sample sets,
// compared against an arithmetic model of the averaged edge position.
module tb_htree_tap_phase_cal;
    localparam int NTAPS    = 8;
    localparam int AVG_LOG2 = 4;
    localparam int S        = 1 << AVG_LOG2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [NTAPS-1:0] samples [S];
    int               expResult;
    int               expBubble;
    int               lastResult;
    int               lastBubble;

    htree_tap_phase_cal_if #(.NTAPS(NTAPS)) calIf ();

    htree_tap_phase_cal #(
        .NTAPS   (NTAPS),
        .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cal(calIf.slave)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Edge position of one sample: the longest run of ones starting at bit 0
    // (or the number of ones when the bubble-tolerant decode is built).
    function automatic int modelCode(input logic [NTAPS-1:0] v);
        int best;
        int mask;
        best = 0;
`ifdef HTREE_CAL_BUBBLE_FIX_EN
        best = $countones(v);
`else
        for (int k = 0; k <= NTAPS; k++) begin
            mask = (1 << k) - 1;
            if ((int'(v) & mask) == mask) best = k;
        end
`endif
        return best;
    endfunction

    // Expected result and bubble flag for the whole sample set.
    task automatic computeExpected();
        int sum;
        sum       = 0;
        expBubble = 0;
        for (int i = 0; i < S; i++) begin
            sum = sum + modelCode(samples[i]);
`ifndef HTREE_CAL_BUBBLE_FIX_EN
            if (int'(samples[i]) != ((1 << modelCode(samples[i])) - 1)) expBubble = 1;
`endif
        end
        expResult = sum / S;
    endtask

    // Runs one measurement starting at the current negedge (cycle 0). Optional
    // start re-pulses at cycles 3 and 10, and optional chained start at cycle S+2.
    task automatic applyStimulus(input bit nagStart, input bit chainNext);
        computeExpected();
        calIf.start = 1'b1;
        for (int c = 1; c <= S + 2; c++) begin
            @(negedge clk);
            calIf.start = 1'b0;
            if (nagStart && (c == 3 || c == 10)) calIf.start = 1'b1;
            checkOutput($sformatf("busy c%0d", c), int'(calIf.busy), (c <= S + 1) ? 1 : 0);
            checkOutput($sformatf("valid c%0d", c), int'(calIf.result_valid), (c == S + 2) ? 1 : 0);
            if (c <= S) calIf.taps_in = samples[c - 1];
            if (c <= S + 1) begin
                checkOutput($sformatf("hold result c%0d", c), int'(calIf.result), lastResult);
                checkOutput($sformatf("hold bubble c%0d", c), int'(calIf.bubble_err), lastBubble);
            end
        end
        checkOutput("result", int'(calIf.result), expResult);
        checkOutput("bubble_err", int'(calIf.bubble_err), expBubble);
        lastResult = expResult;
        lastBubble = expBubble;
        if (chainNext) calIf.start = 1'b1;
    endtask

    task automatic fillAll(input logic [NTAPS-1:0] v);
        for (int i = 0; i < S; i++) samples[i] = v;
    endtask

    // Directed and randomized measurement sequence.
    initial begin
        int sawValid;
        int k;
        checks        = 0;
        errors        = 0;
        lastResult    = 0;
        lastBubble    = 0;
        rst           = 1'b1;
        calIf.start   = 1'b0;
        calIf.taps_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy", int'(calIf.busy), 0);
        checkOutput("reset result", int'(calIf.result), 0);
        checkOutput("reset valid", int'(calIf.result_valid), 0);
        checkOutput("reset bubble", int'(calIf.bubble_err), 0);
        @(negedge clk);

        fillAll(8'h0F);
        applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < S; i++) samples[i] = (i < 8) ? 8'h07 : 8'h1F;
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < S; i++) samples[i] = (i < 15) ? 8'h07 : 8'h0F;
        applyStimulus(1'b0, 1'b0);

        fillAll(8'hFF);
        applyStimulus(1'b0, 1'b0);
        fillAll(8'h00);
        applyStimulus(1'b0, 1'b0);

        fillAll(8'h0B);
        applyStimulus(1'b0, 1'b0);
        fillAll(8'h03);
        applyStimulus(1'b0, 1'b0);

        // Load a nonzero result so the abort clearing is observable.
        fillAll(8'hFF);
        applyStimulus(1'b0, 1'b0);
        calIf.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            calIf.start   = 1'b0;
            calIf.taps_in = 8'h0F;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", int'(calIf.busy), 0);
        checkOutput("abort result", int'(calIf.result), 0);
        checkOutput("abort valid", int'(calIf.result_valid), 0);
        checkOutput("abort bubble", int'(calIf.bubble_err), 0);
        lastResult = 0;
        lastBubble = 0;
        sawValid   = 0;
        for (int c = 0; c < 2 * S; c++) begin
            @(negedge clk);
            if (calIf.result_valid || calIf.busy) sawValid = 1;
        end
        checkOutput("abort no valid", sawValid, 0);
        fillAll(8'h3F);
        applyStimulus(1'b0, 1'b0);

        fillAll(8'h0F);
        applyStimulus(1'b1, 1'b1);
        fillAll(8'h7F);
        applyStimulus(1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < S; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    samples[i] = NTAPS'($urandom);
                end else begin
                    k = int'($urandom_range(0, NTAPS));
                    samples[i] = NTAPS'((1 << k) - 1);
                end
            end
            applyStimulus(1'b0, r[0]);
        end

        @(negedge clk);
        calIf.start = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
